// File: rtl/vproc_div_iter.sv
// Single-lane iterative radix-2 restoring divider for vdiv[u]/vrem[u] at SEW 8/16/32.
// Produces one quotient bit per cycle. Divide-by-zero results are returned right after accept.
module vproc_div_iter #(
  parameter int unsigned DIV_W  = 32,
  parameter type         CTRL_T = logic
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             sync_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  CTRL_T            in_ctrl_i,
  input  logic [1:0]       in_eew_i,
  input  logic             in_signed_i,
  input  logic             in_rem_i,
  input  logic [DIV_W-1:0] in_op1_i,
  input  logic [DIV_W-1:0] in_op2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output CTRL_T            out_ctrl_o,
  output logic [DIV_W-1:0] out_res_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_r, state_next_s;
  logic [4:0]       cnt_r, cnt_next_s;
  logic [DIV_W:0]   rem_r, rem_next_s;
  logic [DIV_W-1:0] dvd_r, dvd_next_s;
  logic [DIV_W-1:0] dvs_r, dvs_next_s;
  logic [DIV_W-1:0] mask_r, mask_next_s;
  logic             neg_q_r, neg_q_next_s;
  logic             neg_r_r, neg_r_next_s;
  logic             sel_rem_r, sel_rem_next_s;
  logic [DIV_W-1:0] res_r, res_next_s;
  logic             valid_r, valid_next_s;
  CTRL_T            ctrl_r, ctrl_next_s;

  logic [DIV_W-1:0] mask_s, op1_ext_s, op2_ext_s, op1_mag_s, op2_mag_s, dvd_init_s;
  logic [4:0]       n_m1_s, shift_s;
  logic             sa_s, sb_s, div_zero_s, accept_s;

  logic [DIV_W:0]   rem_shift_s, rem_it_s;
  logic [DIV_W-1:0] dvd_it_s, q_fin_s, r_fin_s, res_fin_s;

  // Operand decode at accept: EEW mask, extension, magnitudes and dividend alignment
  always_comb begin
    mask_s    = 32'hFFFF_FFFF;
    n_m1_s    = 5'd31;
    shift_s   = 5'd0;
    op1_ext_s = in_op1_i;
    op2_ext_s = in_op2_i;
    case (in_eew_i)
      2'd0: begin
        mask_s    = 32'h0000_00FF;
        n_m1_s    = 5'd7;
        shift_s   = 5'd24;
        op1_ext_s = {{24{in_signed_i & in_op1_i[7]}}, in_op1_i[7:0]};
        op2_ext_s = {{24{in_signed_i & in_op2_i[7]}}, in_op2_i[7:0]};
      end
      2'd1: begin
        mask_s    = 32'h0000_FFFF;
        n_m1_s    = 5'd15;
        shift_s   = 5'd16;
        op1_ext_s = {{16{in_signed_i & in_op1_i[15]}}, in_op1_i[15:0]};
        op2_ext_s = {{16{in_signed_i & in_op2_i[15]}}, in_op2_i[15:0]};
      end
      default: begin
        mask_s    = 32'hFFFF_FFFF;
        n_m1_s    = 5'd31;
        shift_s   = 5'd0;
        op1_ext_s = in_op1_i;
        op2_ext_s = in_op2_i;
      end
    endcase
    sa_s       = in_signed_i & op1_ext_s[31];
    sb_s       = in_signed_i & op2_ext_s[31];
    op1_mag_s  = sa_s ? (32'd0 - op1_ext_s) : op1_ext_s;
    op2_mag_s  = sb_s ? (32'd0 - op2_ext_s) : op2_ext_s;
    dvd_init_s = op1_mag_s << shift_s;
    div_zero_s = ((in_op2_i & mask_s) == 32'd0);
  end

  // One restoring step plus sign fix-up of the final step's outcome
  always_comb begin
    rem_shift_s = {rem_r[DIV_W-1:0], dvd_r[DIV_W-1]};
    if (rem_shift_s >= {1'b0, dvs_r}) begin
      rem_it_s = rem_shift_s - {1'b0, dvs_r};
      dvd_it_s = {dvd_r[DIV_W-2:0], 1'b1};
    end else begin
      rem_it_s = rem_shift_s;
      dvd_it_s = {dvd_r[DIV_W-2:0], 1'b0};
    end
    q_fin_s   = neg_q_r ? (32'd0 - dvd_it_s) : dvd_it_s;
    r_fin_s   = neg_r_r ? (32'd0 - rem_it_s[DIV_W-1:0]) : rem_it_s[DIV_W-1:0];
    res_fin_s = (sel_rem_r ? r_fin_s : q_fin_s) & mask_r;
  end

  // Next-state, handshake and datapath load decisions
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    rem_next_s     = rem_r;
    dvd_next_s     = dvd_r;
    dvs_next_s     = dvs_r;
    mask_next_s    = mask_r;
    neg_q_next_s   = neg_q_r;
    neg_r_next_s   = neg_r_r;
    sel_rem_next_s = sel_rem_r;
    res_next_s     = res_r;
    ctrl_next_s    = ctrl_r;
    in_ready_o     = 1'b0;
    accept_s       = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_o = 1'b1;
        accept_s   = in_valid_i;
      end
      CALC: begin
        rem_next_s = rem_it_s;
        dvd_next_s = dvd_it_s;
        if (cnt_r == 5'd0) begin
          state_next_s = DONE;
          res_next_s   = res_fin_s;
        end else begin
          cnt_next_s = cnt_r - 5'd1;
        end
      end
      DONE: begin
        in_ready_o = out_ready_i;
        if (out_ready_i && in_valid_i) begin
          accept_s = 1'b1;
        end else if (out_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // Zero divisor skips the iterations and presents the special result next cycle
    if (accept_s) begin
      ctrl_next_s    = in_ctrl_i;
      mask_next_s    = mask_s;
      sel_rem_next_s = in_rem_i;
      neg_q_next_s   = sa_s ^ sb_s;
      neg_r_next_s   = sa_s;
      rem_next_s     = 33'd0;
      dvd_next_s     = dvd_init_s;
      dvs_next_s     = op2_mag_s;
      if (div_zero_s) begin
        state_next_s = DONE;
        cnt_next_s   = 5'd0;
        res_next_s   = in_rem_i ? (in_op1_i & mask_s) : mask_s;
      end else begin
        state_next_s = CALC;
        cnt_next_s   = n_m1_s;
      end
    end else begin
      ctrl_next_s = ctrl_r;
    end
    valid_next_s = (state_next_s == DONE);
  end

  // State and datapath registers with async and sync reset
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      rem_r     <= 33'd0;
      dvd_r     <= 32'd0;
      dvs_r     <= 32'd0;
      mask_r    <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
      res_r     <= 32'd0;
      valid_r   <= 1'b0;
      ctrl_r    <= '0;
    end else if (!sync_rst_ni) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      rem_r     <= 33'd0;
      dvd_r     <= 32'd0;
      dvs_r     <= 32'd0;
      mask_r    <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
      res_r     <= 32'd0;
      valid_r   <= 1'b0;
      ctrl_r    <= '0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      rem_r     <= rem_next_s;
      dvd_r     <= dvd_next_s;
      dvs_r     <= dvs_next_s;
      mask_r    <= mask_next_s;
      neg_q_r   <= neg_q_next_s;
      neg_r_r   <= neg_r_next_s;
      sel_rem_r <= sel_rem_next_s;
      res_r     <= res_next_s;
      valid_r   <= valid_next_s;
      ctrl_r    <= ctrl_next_s;
    end
  end

  assign out_valid_o = valid_r;
  assign out_res_o   = res_r;
  assign out_ctrl_o  = ctrl_r;

endmodule

// File: tb/tb_vproc_div_iter.sv
// Directed table-driven bench for vproc_div_iter: results, latency, ctrl pass-through,
// backpressure with same-cycle re-accept, and async/sync reset aborts mid-calculation.
module tb_vproc_div_iter;

  typedef logic [7:0] ctrl_t;

  typedef struct {
    logic [1:0]  eew;
    logic        sgn;
    logic        rem;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        async_rst_n, sync_rst_n;
  logic        in_valid, in_ready, in_signed, in_rem, out_valid, out_ready;
  ctrl_t       in_ctrl, out_ctrl;
  logic [1:0]  in_eew;
  logic [31:0] in_op1, in_op2, out_res;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[15];

  always #5 clk = ~clk;

  vproc_div_iter #(.DIV_W(32), .CTRL_T(ctrl_t)) dut (
    .clk_i        (clk),
    .async_rst_ni (async_rst_n),
    .sync_rst_ni  (sync_rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_ctrl_i    (in_ctrl),
    .in_eew_i     (in_eew),
    .in_signed_i  (in_signed),
    .in_rem_i     (in_rem),
    .in_op1_i     (in_op1),
    .in_op2_i     (in_op2),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_ctrl_o   (out_ctrl),
    .out_res_o    (out_res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] eew, input logic sgn, input logic rem,
                          input logic [31:0] a, input logic [31:0] b, input ctrl_t c);
    in_valid  = 1'b1;
    in_eew    = eew;
    in_signed = sgn;
    in_rem    = rem;
    in_op1    = a;
    in_op2    = b;
    in_ctrl   = c;
  endtask

  // Called #1 after the accept edge; lat counts edges from the accept edge inclusive.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] eew, input logic sgn, input logic rem,
                        input logic [31:0] a, input logic [31:0] b, input ctrl_t c,
                        output logic [31:0] res, output int lat, output ctrl_t co);
    drive_op(eew, sgn, rem, a, b, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    res = out_res;
    co  = out_ctrl;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    ctrl_t       co;
    int          seen;

    vecs[0]  = '{2'd2, 1'b0, 1'b0, 32'd100,       32'd7,        32'h0000_000E, 33};
    vecs[1]  = '{2'd2, 1'b0, 1'b1, 32'd100,       32'd7,        32'h0000_0002, 33};
    vecs[2]  = '{2'd0, 1'b1, 1'b0, 32'hABCD_EFF9, 32'h1234_5602, 32'h0000_00FD, 9};
    vecs[3]  = '{2'd0, 1'b1, 1'b1, 32'hABCD_EFF9, 32'h1234_5602, 32'h0000_00FF, 9};
    vecs[4]  = '{2'd1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_FFFF, 1};
    vecs[5]  = '{2'd1, 1'b0, 1'b1, 32'h0000_1234, 32'hFFFF_0000, 32'h0000_1234, 1};
    vecs[6]  = '{2'd2, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[7]  = '{2'd2, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[8]  = '{2'd1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0003, 32'h0000_5555, 17};
    vecs[9]  = '{2'd1, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 17};
    vecs[10] = '{2'd1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_FFFE, 32'h0000_FFFD, 17};
    vecs[11] = '{2'd1, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_FFFE, 32'h0000_0001, 17};
    vecs[12] = '{2'd0, 1'b0, 1'b0, 32'h1234_56FF, 32'hAB00_0010, 32'h0000_000F, 9};
    vecs[13] = '{2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
    vecs[14] = '{2'd0, 1'b1, 1'b1, 32'h0000_0085, 32'h0000_FF00, 32'h0000_0085, 1};

    async_rst_n = 1'b0;
    sync_rst_n  = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    drive_op(2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 8'h00);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    check("reset_res", out_res, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].eew, vecs[i].sgn, vecs[i].rem, vecs[i].op1, vecs[i].op2,
             ctrl_t'(i * 7 + 1), res, lat, co);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_ctrl", i), {24'd0, co}, {24'd0, ctrl_t'(i * 7 + 1)});
    end

    // Backpressure in DONE, then handshake and new accept on the same edge
    drive_op(2'd0, 1'b0, 1'b0, 32'd9, 32'd3, 8'h5A);
    @(posedge clk);
    #1;
    drive_op(2'd0, 1'b0, 1'b0, 32'd20, 32'd4, 8'hA5);
    wait_valid(lat);
    check("bp_first_lat", 32'(lat), 32'd9);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_res%0d", k), out_res, 32'd3);
      check($sformatf("bp_hold_ctrl%0d", k), {24'd0, out_ctrl}, 32'h0000_005A);
      check($sformatf("bp_hold_ready%0d", k), {30'd0, in_ready, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
    wait_valid(lat);
    check("bp_second_lat", 32'(lat), 32'd9);
    check("bp_second_res", out_res, 32'd5);
    check("bp_second_ctrl", {24'd0, out_ctrl}, 32'h0000_00A5);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drained", {30'd0, out_valid, in_ready}, 32'd1);

    // Async reset aborts a 32-bit op around iteration 10
    run_op(2'd0, 1'b0, 1'b0, 32'd7, 32'd7, 8'h01, res, lat, co);
    drive_op(2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 8'h11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    async_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_res", out_res, 32'd0);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("arst_no_stale_valid", 32'(seen), 32'd0);
    run_op(2'd0, 1'b0, 1'b0, 32'd9, 32'd3, 8'h22, res, lat, co);
    check("arst_next_res", res, 32'd3);
    check("arst_next_lat", 32'(lat), 32'd9);

    // Sync reset has the same abort effect
    drive_op(2'd1, 1'b0, 1'b0, 32'h0000_FFFF, 32'd5, 8'h33);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sync_rst_n = 1'b0;
    @(posedge clk);
    #1;
    sync_rst_n = 1'b1;
    check("srst_valid", {31'd0, out_valid}, 32'd0);
    check("srst_ready", {31'd0, in_ready}, 32'd1);
    check("srst_res", out_res, 32'd0);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("srst_no_stale_valid", 32'(seen), 32'd0);
    run_op(2'd1, 1'b1, 1'b1, 32'h0000_FFF9, 32'h0000_0004, 8'h44, res, lat, co);
    check("srst_next_res", res, 32'h0000_FFFD);
    check("srst_next_lat", 32'(lat), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
